wptr_full: RTL and testbench

WPTR_FULL -- requirements
Module: wptr_full

---
 rtl/wptr_full.sv | 74 +++++++
 tb/tb_wptr_full.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-side pointer and status logic for an asynchronous FIFO: binary/Gray write pointer,
// full/almost-full flags, an occupancy estimate and a sticky overflow flag.
module wptr_full #(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                wovf
);

  localparam logic [ADDRSIZE:0] AfullThr = AFULL_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] full_cmp;
  logic [ADDRSIZE:0] occ_next;
  logic              wr_ok;
  logic              ovf_set;

  assign wr_ok     = winc & ~wfull;
  assign ovf_set   = winc & wfull;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wr_ok};
  assign wgraynext = wbinnext ^ (wbinnext >> 1);
  assign waddr     = wbin[ADDRSIZE-1:0];

  // Full when the write pointer is exactly one lap ahead of the read pointer: in Gray code
  // that is the read pointer with its two MSBs inverted.
  assign full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  always_comb begin
    rbin_s = '0;
    rbin_s[ADDRSIZE] = wq2_rptr[ADDRSIZE];
    for (int i = int'(ADDRSIZE) - 1; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
    end
  end

  assign occ_next = wbinnext - rbin_s;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      wovf         <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= (wgraynext == full_cmp);
      walmost_full <= (occ_next >= AfullThr);
      wcount       <= occ_next;
      // A new overflow takes priority over a clear on the same edge.
      if (ovf_set) begin
        wovf <= 1'b1;
      end else if (wovf_clr) begin
        wovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full: directed scenarios plus random writes/reads, checked against an
// occupancy model built from unbounded write and read counts.
module tb_wptr_full;

  localparam int unsigned AW = 4;

  logic          wclk;
  logic          wrst;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic          wovf_clr;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wcount;
  logic          wovf;

  int n_total;
  int n_bad;

  // Model state: total accepted writes, total reads, registered flags.
  int unsigned m_wr;
  int unsigned rd;
  int unsigned m_occ;
  logic        m_full;
  logic        m_afull;
  logic        m_ovf;

  wptr_full #(
    .ADDRSIZE    (AW),
    .AFULL_THRESH(12)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .wovf_clr    (wovf_clr),
    .waddr       (waddr),
    .wptr        (wptr),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wcount      (wcount),
    .wovf        (wovf)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  function automatic logic [AW:0] gray(input int unsigned b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("waddr", waddr, m_wr % 16);
    check("wptr", wptr, gray(m_wr));
    check("wfull", wfull, m_full);
    check("walmost_full", walmost_full, m_afull);
    check("wcount", wcount, m_occ);
    check("wovf", wovf, m_ovf);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_waddr"}, waddr, 0);
    check({tag, "_wptr"}, wptr, 0);
    check({tag, "_wfull"}, wfull, 0);
    check({tag, "_walmost_full"}, walmost_full, 0);
    check({tag, "_wcount"}, wcount, 0);
    check({tag, "_wovf"}, wovf, 0);
  endtask

  // One clock: apply inputs, advance the model, sample after the edge.
  task automatic step(input logic inc, input logic clr);
    winc     = inc;
    wovf_clr = clr;
    wq2_rptr = gray(rd);
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (inc && !m_full) m_wr++;
    m_occ   = m_wr - rd;
    m_full  = (m_occ == 16);
    m_afull = (m_occ >= 12);
    @(posedge wclk);
    #1;
    check_model();
  endtask

  task automatic model_reset();
    m_wr = 0; rd = 0; m_occ = 0;
    m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
  endtask

  // Called 1 time unit after an edge; reset pulse stays clear of the next edge.
  task automatic mid_reset(input string tag);
    wrst = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
    #2;
    wrst = 1'b0;
  endtask

  logic [AW:0] prev_wptr;

  initial begin
    n_total = 0; n_bad = 0;
    model_reset();
    wrst = 1'b0; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
    #1 wrst = 1'b1;
    #1 check_zero("rst_noclk");
    @(posedge wclk);
    #1 wrst = 1'b0;
    step(1'b0, 1'b0);
    check_zero("rst_idle");

    // Fill from empty.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0);
      if (i == 12) begin
        check("fill12_wcount", wcount, 12);
        check("fill12_afull", walmost_full, 1);
        check("fill12_wfull", wfull, 0);
      end
    end
    check("fill16_wfull", wfull, 1);
    check("fill16_wptr", wptr, 5'b11000);
    check("fill16_wcount", wcount, 16);
    check("fill16_waddr", waddr, 0);

    // Overflow, clear, simultaneous overflow + clear.
    step(1'b1, 1'b0);
    check("ovf_wptr", wptr, 5'b11000);
    check("ovf_set", wovf, 1);
    step(1'b0, 1'b1);
    check("ovf_clr", wovf, 0);
    step(1'b1, 1'b1);
    check("ovf_set_wins", wovf, 1);
    step(1'b0, 1'b1);

    // Reader drains all 16; write in that same cycle is still blocked.
    rd = 16;
    step(1'b1, 1'b0);
    check("drain_wfull", wfull, 0);
    check("drain_wcount", wcount, 0);
    check("drain_afull", walmost_full, 0);
    check("drain_blocked_wptr", wptr, 5'b11000);
    check("drain_blocked_ovf", wovf, 1);
    step(1'b0, 1'b1);

    // 20 more writes: wrap of waddr, full only after 16 entries.
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0);
      if (i == 15) check("wrap15_wfull", wfull, 0);
      if (i == 16) begin
        check("wrap16_wfull", wfull, 1);
        check("wrap16_waddr", waddr, 0);
        check("wrap16_wptr", wptr, 0);
      end
    end

    // Reset mid-burst, then refill exactly.
    rd = m_wr;
    step(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    check("pre_rst_wcount", wcount, 9);
    mid_reset("rst_mid");
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0);
      if (i == 15) check("refill15_wfull", wfull, 0);
    end
    check("refill16_wfull", wfull, 1);

    // Random writes with a reader that never passes the committed writes.
    mid_reset("rst_rand");
    prev_wptr = wptr;
    for (int c = 0; c < 2000; c++) begin
      if (rd < m_wr && ($urandom % 3) != 0) rd++;
      step(($urandom % 4) != 0, ($urandom % 8) == 0);
      check("gray_one_bit", ($countones(wptr ^ prev_wptr) <= 1) ? 1 : 0, 1);
      check("occ_bound", (wcount <= 16) ? 1 : 0, 1);
      prev_wptr = wptr;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
